vram_arb: RTL and testbench
===========================

VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: write FIFO entries; power of 2, 2..16.
REQ-002 Parameter HI_WM, default 3: FIFO occupancy at or above which writes win arbitration; 1..FIFO_DEPTH.
REQ-003 mck  in  1  system clock; all logic on rising edge.
REQ-004 rin  in  1  synchronous, active-high reset.
REQ-005 lcdon  in  1  LCD enable; low flushes pending writes.
REQ-006 w_we  in  1  screen-writer nibble strobe; one push per cycle high, never stalled.
REQ-007 w_a  in  14  write address.
REQ-008 w_d  in  4  write nibble.
REQ-009 rd_req  in  1  scanout read request; held high until rd_ack.
REQ-010 rd_a  in  14  read address; stable while rd_req high.
REQ-011 rd_ack  out  1  one-cycle pulse: read issued to RAM this cycle.
REQ-012 rd_vld  out  1  one-cycle pulse: rd_d valid.
REQ-013 rd_d  out  4  read nibble.
REQ-014 ram_a  out  14  single-port VRAM address.
REQ-015 ram_di  out  4  VRAM write data.
REQ-016 ram_we  out  1  VRAM write enable.
REQ-017 ram_do  in  4  VRAM read data; valid one cycle after address presented.
REQ-018 ovf  out  1  sticky: a write was dropped.
REQ-019 fifo_cnt  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-020 Write path: each w_we=1 cycle pushes {w_a,w_d} into a FIFO_DEPTH-entry FIFO.
REQ-021 Exactly one RAM operation (read, write or idle) per cycle; ram_a/ram_di/ram_we registered, driven the cycle after the decision.
REQ-022 Arbitration per cycle, priority order: (a) fifo_cnt>=HI_WM -> write; (b) rd_req and no read in flight awaiting ack -> read; (c) fifo_cnt>0 -> write; (d) idle.
REQ-023 Write grant pops FIFO head; ram_we=1 with head address/data for one cycle.
REQ-024 Read grant: rd_ack=1 in the cycle ram_a=rd_a with ram_we=0; rd_vld=1 and rd_d=ram_do exactly one cycle later (2 cycles from rd_req sample to rd_vld).
REQ-025 rd_req still high in the cycle after rd_ack is a new request; back-to-back reads sustain one per cycle when fifo_cnt<HI_WM.
REQ-026 Push and pop in the same cycle: occupancy unchanged; FIFO at FIFO_DEPTH with simultaneous pop accepts the push.
REQ-027 Push at fifo_cnt==FIFO_DEPTH without pop: entry dropped, FIFO unchanged, ovf set to 1 until rin.
REQ-028 Push into empty FIFO eligible for arbitration next cycle (no same-cycle bypass).
REQ-029 lcdon=0: FIFO flushed (fifo_cnt=0), pushes ignored, no write grants, no ovf change; reads still served.
REQ-030 Write and read to same address: RAM order equals grant order; no forwarding.
REQ-031 Idle: ram_we=0, ram_a holds last value.

Reset
REQ-032 rin=1 at a rising edge: FIFO empty, fifo_cnt=0, ovf=0, rd_ack=0, rd_vld=0, rd_d=0, ram_we=0, ram_a=0, ram_di=0.
REQ-033 Reset mid-operation: pending writes discarded; an in-flight read produces no rd_vld; requester re-requests.
REQ-034 First grant possible in first cycle after rin deasserts.

Structure
REQ-035 Shared package z88_vram_pkg holds VRAM address width 14, nibble width 4, defaults for FIFO_DEPTH/HI_WM.
REQ-036 One sub-module: vram_wfifo (synchronous FIFO with push, pop, flush, count, full/empty).
REQ-037 Arbiter decision and RAM-port registers stay in vram_arb.

Verification
REQ-038 Reset, then w_we pulse a=0x0105 d=0xA, rd_req low -> ram_we=1 a=0x0105 di=0xA within 2 cycles; fifo_cnt back to 0.
REQ-039 rd_req held a=0x1234, ram_do model returns 0x5, FIFO empty -> rd_ack next cycle, rd_vld with rd_d=0x5 one cycle later.
REQ-040 rd_req continuous, 3 consecutive writes -> reads served until fifo_cnt=3, then a write wins; all 3 writes reach RAM, no ovf.
REQ-041 rd_req continuous, 8 consecutive writes with FIFO_DEPTH=4 -> writes win at HI_WM; ovf=0 if pops keep pace, else ovf=1 and dropped count matches model.
REQ-042 Fill FIFO with 2 entries, drop lcdon -> fifo_cnt=0 next cycle, no ram_we; reads still acked.
REQ-043 Assert rin with read in flight and 2 writes queued -> no rd_vld, no ram_we after reset, all outputs at reset values.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared VRAM widths, arbiter defaults and the types used by the arbiter and its write FIFO.
package z88_vram_pkg;

    localparam int unsigned VRAM_AW        = 14;
    localparam int unsigned VRAM_DW        = 4;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned HI_WM_DEF      = 3;

    typedef struct packed {
        logic [VRAM_AW-1:0] a;
        logic [VRAM_DW-1:0] d;
    } wentry_t;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_RD,
        GNT_WR
    } gnt_e;

endpackage

// File: rtl/vram_arb_if.sv
// Bundle of the writer, scanout-reader and VRAM port signals around the arbiter.
interface vram_arb_if import z88_vram_pkg::*; #(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic               lcdon;
    logic               w_we;
    logic [VRAM_AW-1:0] w_a;
    logic [VRAM_DW-1:0] w_d;
    logic               rd_req;
    logic [VRAM_AW-1:0] rd_a;
    logic               rd_ack;
    logic               rd_vld;
    logic [VRAM_DW-1:0] rd_d;
    logic [VRAM_AW-1:0] ram_a;
    logic [VRAM_DW-1:0] ram_di;
    logic               ram_we;
    logic [VRAM_DW-1:0] ram_do;
    logic               ovf;
    logic [CW-1:0]      fifo_cnt;

    modport slave (
        input  lcdon, w_we, w_a, w_d, rd_req, rd_a, ram_do,
        output rd_ack, rd_vld, rd_d, ram_a, ram_di, ram_we, ovf, fifo_cnt
    );

    modport master (
        output lcdon, w_we, w_a, w_d, rd_req, rd_a, ram_do,
        input  rd_ack, rd_vld, rd_d, ram_a, ram_di, ram_we, ovf, fifo_cnt
    );

endinterface

// File: rtl/vram_wfifo.sv
// Synchronous write FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module vram_wfifo import z88_vram_pkg::*; #(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  wentry_t                wdata_i,
    output wentry_t                rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wentry_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/vram_arb.sv
// Single-port VRAM arbiter: buffered screen writes versus scanout reads, one RAM operation per cycle.
module vram_arb import z88_vram_pkg::*; #(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned HI_WM      = HI_WM_DEF
) (
    input logic       mck,
    input logic       rin,
    vram_arb_if.slave bus
);
    localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] HI_WM_C = CW'(HI_WM);

    wentry_t            wr_entry, head;
    logic [CW-1:0]      cnt;
    logic               full, empty, push, pop, drop;
    gnt_e               gnt;

    logic [VRAM_AW-1:0] ram_a_q, ram_a_d;
    logic [VRAM_DW-1:0] ram_di_q, ram_di_d;
    logic               ram_we_q, ram_we_d;
    logic               rd_ack_q, rd_ack_d;
    logic               rd_vld_q, rd_vld_d;
    logic               ovf_q, ovf_d;

    assign wr_entry.a = bus.w_a;
    assign wr_entry.d = bus.w_d;
    assign push       = bus.lcdon && bus.w_we;
    assign pop        = (gnt == GNT_WR);
    assign drop       = push && full && !pop;

    vram_wfifo #(.DEPTH(FIFO_DEPTH)) u_wfifo (
        .clk_i   (mck),
        .rst_i   (rin),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (!bus.lcdon),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .count_o (cnt),
        .full_o  (full),
        .empty_o (empty)
    );

    // rd_ack is registered, so every cycle rd_req is high at a decision is a fresh request;
    // the requester advances rd_a (or drops rd_req) in the cycle it sees rd_ack.
    always_comb begin
        gnt = GNT_IDLE;
        if (bus.lcdon && (cnt >= HI_WM_C)) gnt = GNT_WR;
        else if (bus.rd_req)               gnt = GNT_RD;
        else if (bus.lcdon && !empty)      gnt = GNT_WR;
    end

    always_comb begin
        ram_a_d  = ram_a_q;
        ram_di_d = ram_di_q;
        ram_we_d = 1'b0;
        rd_ack_d = 1'b0;
        rd_vld_d = rd_ack_q;
        ovf_d    = ovf_q || drop;
        case (gnt)
            GNT_WR: begin
                ram_we_d = 1'b1;
                ram_a_d  = head.a;
                ram_di_d = head.d;
            end
            GNT_RD: begin
                rd_ack_d = 1'b1;
                ram_a_d  = bus.rd_a;
            end
            default: ;
        endcase
    end

    always_ff @(posedge mck) begin
        if (rin) begin
            ram_a_q  <= '0;
            ram_di_q <= '0;
            ram_we_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_vld_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            ram_a_q  <= ram_a_d;
            ram_di_q <= ram_di_d;
            ram_we_q <= ram_we_d;
            rd_ack_q <= rd_ack_d;
            rd_vld_q <= rd_vld_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.ram_a    = ram_a_q;
    assign bus.ram_di   = ram_di_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.rd_ack   = rd_ack_q;
    assign bus.rd_vld   = rd_vld_q;
    assign bus.rd_d     = rd_vld_q ? bus.ram_do : '0;
    assign bus.ovf      = ovf_q;
    assign bus.fifo_cnt = cnt;

endmodule

// File: tb/tb_vram_arb.sv
// Self-checking bench for vram_arb: a queue-based reference of the arbitration rules plus a VRAM model.
module tb_vram_arb;
    import z88_vram_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HWM   = 3;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic mck = 1'b0;
    logic rin;
    int   errors = 0;
    int   checks = 0;

    vram_arb_if #(.FIFO_DEPTH(DEPTH)) bus ();

    vram_arb #(.FIFO_DEPTH(DEPTH), .HI_WM(HWM)) dut (
        .mck (mck),
        .rin (rin),
        .bus (bus)
    );

    always #5 mck = ~mck;

    // VRAM: synchronous read, data valid the cycle after the address.
    logic [3:0] ram    [16384];
    logic [3:0] shadow [16384];

    always @(posedge mck) begin
        logic [3:0] rv;
        rv = ram[bus.ram_a];
        if (bus.ram_we) ram[bus.ram_a] = bus.ram_di;
        bus.ram_do <= rv;
    end

    // Reference: pending writes as a queue, the RAM operation chosen by priority each cycle.
    wentry_t       wq[$];
    logic          m_we = 1'b0, m_ack = 1'b0, m_vld = 1'b0, m_ovf = 1'b0;
    logic [13:0]   m_a = '0;
    logic [3:0]    m_di = '0, m_rd = '0;
    logic [CW-1:0] m_cnt = '0;
    int            m_pushed = 0, m_drops = 0;

    always @(posedge mck) begin
        wentry_t e;
        int      n;
        if (m_we) shadow[m_a] = m_di;
        m_vld = m_ack;
        if (m_ack) m_rd = shadow[m_a];
        if (rin) begin
            wq.delete();
            {m_we, m_ack, m_vld, m_ovf} = '0;
            m_a = '0; m_di = '0; m_rd = '0;
        end else begin
            n = wq.size();
            if ((bus.lcdon && n >= HWM) || (!bus.rd_req && bus.lcdon && n > 0)) begin
                e = wq.pop_front();
                m_we = 1'b1; m_ack = 1'b0; m_a = e.a; m_di = e.d;
            end else if (bus.rd_req) begin
                m_we = 1'b0; m_ack = 1'b1; m_a = bus.rd_a;
            end else begin
                m_we = 1'b0; m_ack = 1'b0;
            end
            if (!bus.lcdon) wq.delete();
            else if (bus.w_we) begin
                m_pushed++;
                e.a = bus.w_a; e.d = bus.w_d;
                if (wq.size() < DEPTH) wq.push_back(e);
                else begin m_ovf = 1'b1; m_drops++; end
            end
        end
        m_cnt = CW'(wq.size());
    end

    task automatic tick();
        @(negedge mck);
    endtask

    task automatic idle_inputs();
        bus.w_we = 1'b0; bus.rd_req = 1'b0; bus.lcdon = 1'b1;
    endtask

    task automatic test_reset();
        rin = 1'b1; idle_inputs();
        repeat (3) tick();
        checks += 8;
        if (bus.rd_ack !== 1'b0)   begin errors++; $display("FAIL reset_rd_ack got=%b exp=0", bus.rd_ack); end
        if (bus.rd_vld !== 1'b0)   begin errors++; $display("FAIL reset_rd_vld got=%b exp=0", bus.rd_vld); end
        if (bus.rd_d !== 4'h0)     begin errors++; $display("FAIL reset_rd_d got=%h exp=0", bus.rd_d); end
        if (bus.ram_we !== 1'b0)   begin errors++; $display("FAIL reset_ram_we got=%b exp=0", bus.ram_we); end
        if (bus.ram_a !== 14'h0)   begin errors++; $display("FAIL reset_ram_a got=%h exp=0", bus.ram_a); end
        if (bus.ram_di !== 4'h0)   begin errors++; $display("FAIL reset_ram_di got=%h exp=0", bus.ram_di); end
        if (bus.ovf !== 1'b0)      begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
        if (bus.fifo_cnt !== '0)   begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.fifo_cnt); end
        // first cycle out of reset can already grant
        rin = 1'b0; bus.rd_req = 1'b1; bus.rd_a = 14'h2AAA;
        tick();
        bus.rd_req = 1'b0;
        checks += 2;
        if (bus.rd_ack !== 1'b1)   begin errors++; $display("FAIL first_grant_ack got=%b exp=1", bus.rd_ack); end
        if (bus.ram_a !== 14'h2AAA) begin errors++; $display("FAIL first_grant_a got=%h exp=2aaa", bus.ram_a); end
        tick();
        checks += 2;
        if (bus.rd_vld !== 1'b1)   begin errors++; $display("FAIL first_grant_vld got=%b exp=1", bus.rd_vld); end
        if (bus.rd_d !== shadow[14'h2AAA]) begin errors++; $display("FAIL first_grant_d got=%h exp=%h", bus.rd_d, shadow[14'h2AAA]); end
    endtask

    task automatic test_single_write();
        int waited = 0;
        bus.w_we = 1'b1; bus.w_a = 14'h0105; bus.w_d = 4'hA;
        tick();
        bus.w_we = 1'b0;
        while (bus.ram_we !== 1'b1 && waited < 2) begin tick(); waited++; end
        checks += 3;
        if (bus.ram_we !== 1'b1)    begin errors++; $display("FAIL wr_latency ram_we=%b after %0d cycles, exp 1 within 2", bus.ram_we, waited); end
        if (bus.ram_a !== 14'h0105) begin errors++; $display("FAIL wr_addr got=%h exp=0105", bus.ram_a); end
        if (bus.ram_di !== 4'hA)    begin errors++; $display("FAIL wr_data got=%h exp=a", bus.ram_di); end
        tick();
        checks += 2;
        if (bus.fifo_cnt !== '0)    begin errors++; $display("FAIL wr_cnt_after got=%0d exp=0", bus.fifo_cnt); end
        if (bus.ram_we !== 1'b0)    begin errors++; $display("FAIL wr_once ram_we=%b exp=0", bus.ram_we); end
    endtask

    task automatic test_single_read();
        ram[14'h1234] = 4'h5; shadow[14'h1234] = 4'h5;
        bus.rd_req = 1'b1; bus.rd_a = 14'h1234;
        tick();
        checks += 3;
        if (bus.rd_ack !== 1'b1)    begin errors++; $display("FAIL rd_ack got=%b exp=1", bus.rd_ack); end
        if (bus.ram_a !== 14'h1234) begin errors++; $display("FAIL rd_addr got=%h exp=1234", bus.ram_a); end
        if (bus.ram_we !== 1'b0)    begin errors++; $display("FAIL rd_no_we got=%b exp=0", bus.ram_we); end
        bus.rd_req = 1'b0;
        tick();
        checks += 3;
        if (bus.rd_vld !== 1'b1)    begin errors++; $display("FAIL rd_vld got=%b exp=1", bus.rd_vld); end
        if (bus.rd_d !== 4'h5)      begin errors++; $display("FAIL rd_data got=%h exp=5", bus.rd_d); end
        if (bus.rd_ack !== 1'b0)    begin errors++; $display("FAIL rd_single_ack got=%b exp=0", bus.rd_ack); end
        tick();
        checks++;
        if (bus.rd_vld !== 1'b0)    begin errors++; $display("FAIL rd_vld_pulse got=%b exp=0", bus.rd_vld); end
    endtask

    task automatic test_back_to_back();
        bus.rd_req = 1'b1; bus.rd_a = 14'($urandom);
        for (int c = 0; c < 8; c++) begin
            tick();
            checks += 3;
            if (bus.rd_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack c=%0d got=%b exp=1", c, bus.rd_ack); end
            if (bus.ram_a !== m_a)   begin errors++; $display("FAIL b2b_addr c=%0d got=%h exp=%h", c, bus.ram_a, m_a); end
            if (c > 0 && (bus.rd_vld !== 1'b1 || bus.rd_d !== m_rd)) begin
                errors++; $display("FAIL b2b_data c=%0d vld=%b d=%h exp vld=1 d=%h", c, bus.rd_vld, bus.rd_d, m_rd);
            end
            bus.rd_a = 14'($urandom);
        end
        bus.rd_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_watermark(input int nwrites, input string tag);
        int  nwr = 0;
        int  p0 = m_pushed, d0 = m_drops;
        bit  wr_during_rd = 0;
        bus.rd_req = 1'b1; bus.rd_a = 14'($urandom);
        for (int c = 0; c < nwrites + 6; c++) begin
            bus.w_we = (c < nwrites); bus.w_a = 14'($urandom_range(0, 63)); bus.w_d = 4'($urandom);
            tick();
            checks += 3;
            if (bus.ram_we !== m_we)     begin errors++; $display("FAIL %s_we c=%0d got=%b exp=%b", tag, c, bus.ram_we, m_we); end
            if (bus.rd_ack !== m_ack)    begin errors++; $display("FAIL %s_ack c=%0d got=%b exp=%b", tag, c, bus.rd_ack, m_ack); end
            if (bus.fifo_cnt !== m_cnt)  begin errors++; $display("FAIL %s_cnt c=%0d got=%0d exp=%0d", tag, c, bus.fifo_cnt, m_cnt); end
            if (bus.ram_we === 1'b1) begin nwr++; wr_during_rd = 1; end
            if (bus.rd_ack === 1'b1) bus.rd_a = 14'($urandom);
        end
        bus.w_we = 1'b0; bus.rd_req = 1'b0;
        for (int c = 0; c < 8; c++) begin tick(); if (bus.ram_we === 1'b1) nwr++; end
        checks += 4;
        if (!wr_during_rd)              begin errors++; $display("FAIL %s_hiwm_win got=0 exp=1", tag); end
        if (nwr != (m_pushed - p0) - (m_drops - d0)) begin
            errors++; $display("FAIL %s_writes got=%0d exp=%0d", tag, nwr, (m_pushed - p0) - (m_drops - d0));
        end
        if (bus.ovf !== m_ovf)          begin errors++; $display("FAIL %s_ovf got=%b exp=%b", tag, bus.ovf, m_ovf); end
        if (bus.fifo_cnt !== '0)        begin errors++; $display("FAIL %s_drained got=%0d exp=0", tag, bus.fifo_cnt); end
    endtask

    task automatic test_lcdon_flush();
        int nwr = 0, nack = 0;
        bus.rd_req = 1'b1; bus.rd_a = 14'($urandom);
        for (int c = 0; c < 2; c++) begin
            bus.w_we = 1'b1; bus.w_a = 14'($urandom); bus.w_d = 4'($urandom);
            tick();
            bus.rd_a = 14'($urandom);
        end
        bus.w_we = 1'b0;
        checks++;
        if (bus.fifo_cnt !== CW'(2)) begin errors++; $display("FAIL flush_fill got=%0d exp=2", bus.fifo_cnt); end
        bus.lcdon = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.w_we = 1'b1; bus.w_a = 14'($urandom); bus.w_d = 4'($urandom);
            tick();
            checks++;
            if (bus.fifo_cnt !== '0) begin errors++; $display("FAIL flush_cnt c=%0d got=%0d exp=0", c, bus.fifo_cnt); end
            if (bus.ram_we === 1'b1) nwr++;
            if (bus.rd_ack === 1'b1) begin nack++; bus.rd_a = 14'($urandom); end
        end
        bus.w_we = 1'b0; bus.rd_req = 1'b0; bus.lcdon = 1'b1;
        for (int c = 0; c < 4; c++) begin tick(); if (bus.ram_we === 1'b1) nwr++; end
        checks += 3;
        if (nwr != 0)           begin errors++; $display("FAIL flush_no_write got=%0d exp=0", nwr); end
        if (nack != 5)          begin errors++; $display("FAIL flush_reads got=%0d exp=5", nack); end
        if (bus.ovf !== 1'b0)   begin errors++; $display("FAIL flush_ovf got=%b exp=0", bus.ovf); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        bus.rd_req = 1'b1; bus.rd_a = 14'($urandom);
        for (int c = 0; c < 2; c++) begin
            bus.w_we = 1'b1; bus.w_a = 14'($urandom); bus.w_d = 4'($urandom);
            tick();
            bus.rd_a = 14'($urandom);
        end
        bus.w_we = 1'b0;
        checks += 2;
        if (bus.rd_ack !== 1'b1)     begin errors++; $display("FAIL midrst_inflight got=%b exp=1", bus.rd_ack); end
        if (bus.fifo_cnt !== CW'(2)) begin errors++; $display("FAIL midrst_queued got=%0d exp=2", bus.fifo_cnt); end
        rin = 1'b1; bus.rd_req = 1'b0;
        tick();
        checks += 6;
        if (bus.rd_vld !== 1'b0)     begin errors++; $display("FAIL midrst_vld got=%b exp=0", bus.rd_vld); end
        if (bus.rd_ack !== 1'b0)     begin errors++; $display("FAIL midrst_ack got=%b exp=0", bus.rd_ack); end
        if (bus.ram_we !== 1'b0)     begin errors++; $display("FAIL midrst_we got=%b exp=0", bus.ram_we); end
        if (bus.ram_a !== 14'h0)     begin errors++; $display("FAIL midrst_a got=%h exp=0", bus.ram_a); end
        if (bus.ram_di !== 4'h0)     begin errors++; $display("FAIL midrst_di got=%h exp=0", bus.ram_di); end
        if (bus.fifo_cnt !== '0)     begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", bus.fifo_cnt); end
        rin = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.ram_we !== 1'b0 || bus.rd_vld !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL midrst_quiet got=%0d active cycles exp=0", bad); end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            bus.lcdon = ($urandom_range(0, 19) != 0);
            bus.w_we  = $urandom_range(0, 1);
            bus.w_a   = 14'($urandom_range(0, 15));
            bus.w_d   = 4'($urandom);
            tick();
            checks += 7;
            if (bus.ram_we !== m_we)    begin errors++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, bus.ram_we, m_we); end
            if (bus.ram_a !== m_a)      begin errors++; $display("FAIL rnd_a c=%0d got=%h exp=%h", c, bus.ram_a, m_a); end
            if (bus.ram_di !== m_di)    begin errors++; $display("FAIL rnd_di c=%0d got=%h exp=%h", c, bus.ram_di, m_di); end
            if (bus.rd_ack !== m_ack)   begin errors++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, bus.rd_ack, m_ack); end
            if (bus.rd_vld !== m_vld)   begin errors++; $display("FAIL rnd_vld c=%0d got=%b exp=%b", c, bus.rd_vld, m_vld); end
            if (bus.fifo_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, bus.fifo_cnt, m_cnt); end
            if (bus.ovf !== m_ovf)      begin errors++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, bus.ovf, m_ovf); end
            if (m_vld) begin
                checks++;
                if (bus.rd_d !== m_rd)  begin errors++; $display("FAIL rnd_rd_d c=%0d got=%h exp=%h", c, bus.rd_d, m_rd); end
            end
            if (!bus.rd_req) begin
                bus.rd_req = $urandom_range(0, 1);
                bus.rd_a   = 14'($urandom_range(0, 15));
            end else if (bus.rd_ack === 1'b1) begin
                bus.rd_req = $urandom_range(0, 1);
                bus.rd_a   = 14'($urandom_range(0, 15));
            end
        end
        idle_inputs();
        repeat (8) tick();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            ram[i]    = 4'((i * 7 + 3) % 16);
            shadow[i] = ram[i];
        end
        rin = 1'b1;
        idle_inputs();
        bus.w_a = '0; bus.w_d = '0; bus.rd_a = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_watermark(3, "wm3");
        test_watermark(8, "wm8");
        test_lcdon_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
